// File: rtl/tag_array_assoc.sv
// rtl/tag_array_assoc.sv - set-associative tag array with 1-cycle lookup, victim select, fill and invalidate sweep
module tag_array_assoc #(
    parameter int SETS  = 64,
    parameter int WAYS  = 4,
    parameter int TAG_W = 20,
    localparam int SW   = $clog2(SETS),
    localparam int WW   = $clog2(WAYS)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             lk_valid_i,
    output logic             lk_ready_o,
    input  logic [SW-1:0]    lk_set_i,
    input  logic [TAG_W-1:0] lk_tag_i,
    output logic             rsp_valid_o,
    output logic             rsp_hit_o,
    output logic [WW-1:0]    rsp_way_o,
    output logic [WW-1:0]    rsp_victim_o,
    input  logic             fill_valid_i,
    input  logic [SW-1:0]    fill_set_i,
    input  logic [WW-1:0]    fill_way_i,
    input  logic [TAG_W-1:0] fill_tag_i,
    input  logic             inv_all_i,
    output logic             busy_o,
    output logic             sweep_done_o
);
    typedef enum logic {IDLE, SWEEP} state_e;

    state_e             state_q, state_d;
    logic [SW-1:0]      cnt_q, cnt_d;
    logic [WAYS-1:0]    valid_q [SETS];
    logic [WW-1:0]      ptr_q [SETS];
    logic [TAG_W-1:0]   tag_q [SETS][WAYS];

    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_hit_q, rsp_hit_d;
    logic [WW-1:0]      rsp_way_q, rsp_way_d;
    logic [WW-1:0]      rsp_victim_q, rsp_victim_d;

    logic               busy, lk_fire, fill_fire, last_set;
    logic [WAYS-1:0]    look_valid;
    logic               look_hit;
    logic [WW-1:0]      look_way, look_victim;

    assign busy      = (state_q == SWEEP);
    assign lk_fire   = lk_valid_i && !busy;
    assign fill_fire = fill_valid_i && !busy;
    assign last_set  = (cnt_q == SW'(SETS - 1));

    // Descending scans so the lowest matching / lowest invalid way wins.
    always_comb begin
        look_valid  = valid_q[lk_set_i];
        look_hit    = 1'b0;
        look_way    = '0;
        look_victim = ptr_q[lk_set_i];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (look_valid[w] && (tag_q[lk_set_i][w] == lk_tag_i)) begin
                look_hit = 1'b1;
                look_way = WW'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!look_valid[w]) begin
                look_victim = WW'(w);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (inv_all_i) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                end
            end
            SWEEP: begin
                cnt_d = cnt_q + 1'b1;
                if (last_set) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rsp_valid_d  = lk_fire;
        rsp_hit_d    = rsp_hit_q;
        rsp_way_d    = rsp_way_q;
        rsp_victim_d = rsp_victim_q;
        if (lk_fire) begin
            rsp_hit_d    = look_hit;
            rsp_way_d    = look_way;
            rsp_victim_d = look_victim;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_hit_q    <= 1'b0;
            rsp_way_q    <= '0;
            rsp_victim_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_hit_q    <= rsp_hit_d;
            rsp_way_q    <= rsp_way_d;
            rsp_victim_q <= rsp_victim_d;
        end
    end

    // The pointer only rotates once a set is full, so partially filled sets keep using free ways.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                ptr_q[s]   <= '0;
            end
        end else if (busy) begin
            valid_q[cnt_q] <= '0;
            ptr_q[cnt_q]   <= '0;
        end else if (fill_fire) begin
            valid_q[fill_set_i][fill_way_i] <= 1'b1;
            if (&valid_q[fill_set_i]) begin
                ptr_q[fill_set_i] <= ptr_q[fill_set_i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (fill_fire) begin
            tag_q[fill_set_i][fill_way_i] <= fill_tag_i;
        end
    end

    assign lk_ready_o   = !busy;
    assign busy_o       = busy;
    assign sweep_done_o = busy && last_set;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_hit_o    = rsp_hit_q;
    assign rsp_way_o    = rsp_way_q;
    assign rsp_victim_o = rsp_victim_q;
endmodule

// File: tb/tb_tag_array_assoc.sv
// tb/tb_tag_array_assoc.sv - directed bench with reference model for tag_array_assoc
module tb_tag_array_assoc;
    localparam int SETS  = 64;
    localparam int WAYS  = 4;
    localparam int TAG_W = 20;

    logic clk = 1'b0;
    logic rst_n;
    logic lk_valid, lk_ready, rsp_valid, rsp_hit, fill_valid, inv_all, busy, sweep_done;
    logic [5:0] lk_set, fill_set;
    logic [19:0] lk_tag, fill_tag;
    logic [1:0] rsp_way, rsp_victim, fill_way;

    int checks = 0;
    int errors = 0;
    int busy_cnt = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    tag_array_assoc #(.SETS(SETS), .WAYS(WAYS), .TAG_W(TAG_W)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .lk_valid_i(lk_valid), .lk_ready_o(lk_ready), .lk_set_i(lk_set), .lk_tag_i(lk_tag),
        .rsp_valid_o(rsp_valid), .rsp_hit_o(rsp_hit), .rsp_way_o(rsp_way), .rsp_victim_o(rsp_victim),
        .fill_valid_i(fill_valid), .fill_set_i(fill_set), .fill_way_i(fill_way), .fill_tag_i(fill_tag),
        .inv_all_i(inv_all), .busy_o(busy), .sweep_done_o(sweep_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per-set lists of valid flags/tags, a rotation index and a sweep position.
    bit         mv [SETS][WAYS];
    logic [19:0] mt [SETS][WAYS];
    int         mp [SETS];
    bit         m_active = 0;
    int         m_pos = 0;
    bit         e_rv = 0, e_hit = 0;
    int         e_way = 0, e_vic = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                mp[s] = 0;
                for (int w = 0; w < WAYS; w++) mv[s][w] = 0;
            end
            m_active = 0; m_pos = 0;
            e_rv = 0; e_hit = 0; e_way = 0; e_vic = 0;
        end else begin
            bit full;
            e_rv = lk_valid && !m_active;
            if (e_rv) begin
                int hw, iv;
                hw = -1; iv = -1;
                for (int w = 0; w < WAYS; w++) begin
                    if (hw < 0 && mv[lk_set][w] && mt[lk_set][w] == lk_tag) hw = w;
                    if (iv < 0 && !mv[lk_set][w]) iv = w;
                end
                e_hit = (hw >= 0);
                e_way = (hw >= 0) ? hw : 0;
                e_vic = (iv >= 0) ? iv : mp[lk_set];
            end
            if (fill_valid && !m_active) begin
                full = 1;
                for (int w = 0; w < WAYS; w++) if (!mv[fill_set][w]) full = 0;
                mv[fill_set][fill_way] = 1;
                mt[fill_set][fill_way] = fill_tag;
                if (full) mp[fill_set] = (mp[fill_set] + 1) % WAYS;
            end
            if (m_active) begin
                for (int w = 0; w < WAYS; w++) mv[m_pos][w] = 0;
                mp[m_pos] = 0;
                m_pos++;
                if (m_pos == SETS) m_active = 0;
            end else if (inv_all) begin
                m_active = 1;
                m_pos = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("lk_ready", lk_ready, !m_active);
        chk("busy", busy, m_active);
        chk("sweep_done", sweep_done, m_active && m_pos == SETS - 1);
        chk("rsp_valid", rsp_valid, e_rv);
        chk("rsp_hit", rsp_hit, e_hit);
        chk("rsp_way", rsp_way, e_way);
        chk("rsp_victim", rsp_victim, e_vic);
        if (busy) busy_cnt++;
        if (sweep_done) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input int s, input int t);
        lk_valid = 1; lk_set = 6'(s); lk_tag = 20'(t);
        tick();
        lk_valid = 0;
    endtask

    task automatic fill(input int s, input int w, input int t);
        fill_valid = 1; fill_set = 6'(s); fill_way = 2'(w); fill_tag = 20'(t);
        tick();
        fill_valid = 0;
    endtask

    int vexp [5] = '{0, 1, 2, 3, 0};
    int v;

    initial begin
        rst_n = 1; lk_valid = 0; lk_set = 0; lk_tag = 0;
        fill_valid = 0; fill_set = 0; fill_way = 0; fill_tag = 0; inv_all = 0;
        #2 rst_n = 0;
        tick(); tick();
        chk("reset lk_ready", lk_ready, 1);
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset busy", busy, 0);
        chk("reset sweep_done", sweep_done, 0);
        rst_n = 1;
        tick();

        lookup(5, 'h12345);
        chk("first rsp_valid", rsp_valid, 1);
        chk("first rsp_hit", rsp_hit, 0);
        chk("first rsp_victim", rsp_victim, 0);

        for (int w = 0; w < 4; w++) fill(5, w, 'hA0 + w);
        lookup(5, 'hA2);
        chk("A2 hit", rsp_hit, 1);
        chk("A2 way", rsp_way, 2);
        lookup(5, 'hA4);
        chk("A4 hit", rsp_hit, 0);
        chk("A4 victim", rsp_victim, 0);

        for (int i = 0; i < 5; i++) begin
            lookup(5, 'hC0);
            chk("rr victim", rsp_victim, vexp[i]);
            v = int'(rsp_victim);
            if (i < 4) fill(5, v, 'hB0 + i);
        end

        lk_valid = 1; lk_set = 9; lk_tag = 'h77;
        fill_valid = 1; fill_set = 9; fill_way = 1; fill_tag = 'h77;
        tick();
        lk_valid = 0; fill_valid = 0;
        chk("same-cycle hit", rsp_hit, 0);
        lookup(9, 'h77);
        chk("next-cycle hit", rsp_hit, 1);
        chk("next-cycle way", rsp_way, 1);

        fill(20, 0, 'h300);
        fill(63, 3, 'h3FF);
        busy_cnt = 0; done_cnt = 0;
        inv_all = 1;
        tick();
        inv_all = 0;
        lk_valid = 1; lk_set = 20; lk_tag = 'h300;
        fill_valid = 1; fill_set = 20; fill_way = 2; fill_tag = 'h55;
        repeat (SETS) tick();
        lk_valid = 0; fill_valid = 0;
        chk("sweep end busy", busy, 0);
        chk("sweep busy cycles", busy_cnt, 64);
        chk("sweep done pulses", done_cnt, 1);

        lk_valid = 1;
        for (int s = 0; s < SETS; s++) begin
            lk_set = 6'(s);
            case (s)
                5:       lk_tag = 'hB1;
                9:       lk_tag = 'h77;
                20:      lk_tag = 'h55;
                63:      lk_tag = 'h3FF;
                default: lk_tag = 'h300;
            endcase
            tick();
            chk("post-sweep hit", rsp_hit, 0);
            chk("post-sweep victim", rsp_victim, 0);
        end
        lk_valid = 0;

        fill(9, 1, 'h77);
        fill(40, 0, 'h1);
        busy_cnt = 0; done_cnt = 0;
        inv_all = 1;
        tick();
        inv_all = 0;
        repeat (10) tick();
        rst_n = 0;
        #1;
        chk("mid-reset busy", busy, 0);
        chk("mid-reset lk_ready", lk_ready, 1);
        chk("mid-reset sweep_done", sweep_done, 0);
        @(posedge clk);
        #1 rst_n = 1;
        chk("aborted busy cycles", busy_cnt, 10);
        chk("aborted done pulses", done_cnt, 0);
        lookup(9, 'h77);
        chk("after reset set9 hit", rsp_hit, 0);
        lookup(40, 'h1);
        chk("after reset set40 hit", rsp_hit, 0);
        chk("after reset set40 victim", rsp_victim, 0);

        busy_cnt = 0; done_cnt = 0;
        inv_all = 1;
        tick();
        inv_all = 0;
        repeat (SETS) tick();
        chk("resweep busy cycles", busy_cnt, 64);
        chk("resweep done pulses", done_cnt, 1);
        chk("resweep idle", busy, 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
